// File: rtl/lfsr_decrypt_engine.sv
// lfsr_decrypt_engine: recovers the LFSR seed and tap pattern from a known
// preamble, decrypts the message into data memory, then strips the leading
// preamble characters and pads the freed tail.
module lfsr_decrypt_engine #(
    parameter int                         DATA_W      = 8,
    parameter int                         LFSR_W      = 6,
    parameter int                         NUM_TAPS    = 6,
    parameter logic [NUM_TAPS*LFSR_W-1:0] TAP_TABLE   = {6'h39, 6'h36, 6'h33, 6'h30, 6'h2D, 6'h21},
    parameter int                         MSG_LEN     = 64,
    parameter int                         TRIAL_DEPTH = 7,
    parameter int                         ENC_BASE    = 64,
    parameter int                         DEC_BASE    = 0,
    parameter logic [DATA_W-1:0]          PRE_CHAR    = 8'h5F,
    parameter logic [DATA_W-1:0]          PAD_CHAR    = 8'h20,
    parameter int                         ADDR_W      = 8
) (
    input  logic                         clk,
    input  logic                         init,
    input  logic                         start,
    output logic [ADDR_W-1:0]            mem_raddr,
    input  logic [DATA_W-1:0]            mem_rdata,
    output logic                         mem_we,
    output logic [ADDR_W-1:0]            mem_waddr,
    output logic [DATA_W-1:0]            mem_wdata,
    output logic                         busy,
    output logic                         done,
    output logic                         err,
    output logic [$clog2(NUM_TAPS)-1:0]  tap_idx,
    output logic [$clog2(MSG_LEN+1)-1:0] pre_len
);

    localparam int TI_W  = $clog2(NUM_TAPS);
    localparam int PL_W  = $clog2(MSG_LEN + 1);
    localparam int CNT_W = $clog2(MSG_LEN + 2);
    localparam int OBS_W = TRIAL_DEPTH * LFSR_W;

    localparam logic [ADDR_W-1:0] ENC_A   = ADDR_W'(ENC_BASE);
    localparam logic [ADDR_W-1:0] DEC_A   = ADDR_W'(DEC_BASE);
    localparam logic [CNT_W-1:0]  MSG_C   = CNT_W'(MSG_LEN);
    localparam logic [CNT_W-1:0]  TD_C    = CNT_W'(TRIAL_DEPTH);
    localparam logic [CNT_W-1:0]  ONE_C   = CNT_W'(1);
    localparam logic [CNT_W-1:0]  TWO_C   = CNT_W'(2);
    localparam logic [PL_W-1:0]   MSG_P   = PL_W'(MSG_LEN);
    localparam logic [PL_W-1:0]   ONE_P   = PL_W'(1);
    localparam logic [LFSR_W-1:0] PRE_LOW = PRE_CHAR[LFSR_W-1:0];

    typedef enum logic [2:0] {
        S_IDLE, S_SEED, S_MATCH, S_FAIL, S_DECODE, S_COMPACT, S_PAD, S_DONE
    } state_t;

    function automatic logic [LFSR_W-1:0] lfsr_step(input logic [LFSR_W-1:0] s,
                                                    input logic [LFSR_W-1:0] t);
        return {s[LFSR_W-2:0], ^(s & t)};
    endfunction

    state_t                state_q, state_d;
    logic [CNT_W-1:0]      cnt_q, cnt_d;
    logic [OBS_W-1:0]      obs_q, obs_d;
    logic [LFSR_W-1:0]     cand_q [NUM_TAPS];
    logic [LFSR_W-1:0]     cand_d [NUM_TAPS];
    logic [LFSR_W-1:0]     cand_nxt [NUM_TAPS];
    logic [NUM_TAPS-1:0]   alive_q, alive_d;
    logic [LFSR_W-1:0]     s_q, s_d;
    logic [LFSR_W-1:0]     tap_q, tap_d;
    logic [TI_W-1:0]       tap_idx_q, tap_idx_d;
    logic [PL_W-1:0]       pre_len_q, pre_len_d;
    logic                  pre_run_q, pre_run_d;
    logic                  err_q, err_d;
    logic [DATA_W-1:0]     dec_char;
    logic [CNT_W-1:0]      pre_c;
    logic [CNT_W-1:0]      comp_n;

    assign dec_char = mem_rdata ^ DATA_W'(s_q);
    assign pre_c    = CNT_W'(pre_len_q);
    assign comp_n   = MSG_C - pre_c;
    assign tap_idx  = tap_idx_q;
    assign pre_len  = pre_len_q;
    assign err      = err_q;

    // Advance every candidate LFSR by one step under its own tap pattern.
    always_comb begin
        for (int i = 0; i < NUM_TAPS; i++) begin
            cand_nxt[i] = lfsr_step(cand_q[i], TAP_TABLE[i*LFSR_W +: LFSR_W]);
        end
    end

    // Next-state logic and memory port drive for every phase of a run.
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q + ONE_C;
        obs_d     = obs_q;
        cand_d    = cand_q;
        alive_d   = alive_q;
        s_d       = s_q;
        tap_d     = tap_q;
        tap_idx_d = tap_idx_q;
        pre_len_d = pre_len_q;
        pre_run_d = pre_run_q;
        err_d     = err_q;
        mem_raddr = '0;
        mem_we    = 1'b0;
        mem_waddr = '0;
        mem_wdata = '0;
        busy      = 1'b0;
        done      = 1'b0;
        case (state_q)
            S_IDLE: begin
                cnt_d = '0;
                if (start) begin
                    err_d     = 1'b0;
                    pre_len_d = '0;
                    tap_idx_d = '0;
                    state_d   = S_SEED;
                end
            end
            S_SEED: begin
                busy = 1'b1;
                if (cnt_q < TD_C) begin
                    mem_raddr = ENC_A + ADDR_W'(cnt_q);
                end
                if (cnt_q != '0) begin
                    obs_d = {mem_rdata[LFSR_W-1:0] ^ PRE_LOW, obs_q[OBS_W-1:LFSR_W]};
                end
                if (cnt_q == TD_C) begin
                    state_d = S_MATCH;
                    cnt_d   = '0;
                    s_d     = obs_d[LFSR_W-1:0];
                    alive_d = '1;
                    for (int i = 0; i < NUM_TAPS; i++) begin
                        cand_d[i] = obs_d[LFSR_W-1:0];
                    end
                end
            end
            S_MATCH: begin
                busy  = 1'b1;
                obs_d = obs_q >> LFSR_W;
                for (int i = 0; i < NUM_TAPS; i++) begin
                    cand_d[i]  = cand_nxt[i];
                    alive_d[i] = alive_q[i] & (cand_nxt[i] == obs_q[2*LFSR_W-1:LFSR_W]);
                end
                if (cnt_q == TD_C - TWO_C) begin
                    cnt_d = '0;
                    if (|alive_d) begin
                        state_d   = S_DECODE;
                        pre_run_d = 1'b1;
                        for (int i = NUM_TAPS - 1; i >= 0; i--) begin
                            if (alive_d[i]) begin
                                tap_idx_d = TI_W'(i);
                                tap_d     = TAP_TABLE[i*LFSR_W +: LFSR_W];
                            end
                        end
                    end else begin
                        state_d = S_FAIL;
                        err_d   = 1'b1;
                    end
                end
            end
            S_FAIL: begin
                done    = 1'b1;
                state_d = S_IDLE;
            end
            S_DECODE: begin
                busy = 1'b1;
                if (cnt_q < MSG_C) begin
                    mem_raddr = ENC_A + ADDR_W'(cnt_q);
                end
                if (cnt_q != '0) begin
                    mem_we    = 1'b1;
                    mem_waddr = DEC_A + ADDR_W'(cnt_q - ONE_C);
                    mem_wdata = dec_char;
                    s_d       = lfsr_step(s_q, tap_q);
                    if (pre_run_q && (dec_char == PRE_CHAR)) begin
                        pre_len_d = pre_len_q + ONE_P;
                    end else begin
                        pre_run_d = 1'b0;
                    end
                end
                if (cnt_q == MSG_C) begin
                    cnt_d = '0;
                    if (pre_len_d == '0) begin
                        state_d = S_DONE;
                    end else if (pre_len_d == MSG_P) begin
                        state_d = S_PAD;
                    end else begin
                        state_d = S_COMPACT;
                    end
                end
            end
            S_COMPACT: begin
                busy = 1'b1;
                if (cnt_q < comp_n) begin
                    mem_raddr = DEC_A + ADDR_W'(pre_len_q) + ADDR_W'(cnt_q);
                end
                if (cnt_q != '0) begin
                    mem_we    = 1'b1;
                    mem_waddr = DEC_A + ADDR_W'(cnt_q - ONE_C);
                    mem_wdata = mem_rdata;
                end
                if (cnt_q == comp_n) begin
                    state_d = S_PAD;
                    cnt_d   = '0;
                end
            end
            S_PAD: begin
                busy      = 1'b1;
                mem_we    = 1'b1;
                mem_waddr = DEC_A + ADDR_W'(comp_n + cnt_q);
                mem_wdata = PAD_CHAR;
                if (cnt_q == pre_c - ONE_C) begin
                    state_d = S_DONE;
                    cnt_d   = '0;
                end
            end
            S_DONE: begin
                done    = 1'b1;
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // State and datapath registers; init aborts a run immediately.
    always_ff @(posedge clk or posedge init) begin
        if (init) begin
            state_q   <= S_IDLE;
            cnt_q     <= '0;
            obs_q     <= '0;
            for (int i = 0; i < NUM_TAPS; i++) begin
                cand_q[i] <= '0;
            end
            alive_q   <= '0;
            s_q       <= '0;
            tap_q     <= '0;
            tap_idx_q <= '0;
            pre_len_q <= '0;
            pre_run_q <= 1'b0;
            err_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            obs_q     <= obs_d;
            cand_q    <= cand_d;
            alive_q   <= alive_d;
            s_q       <= s_d;
            tap_q     <= tap_d;
            tap_idx_q <= tap_idx_d;
            pre_len_q <= pre_len_d;
            pre_run_q <= pre_run_d;
            err_q     <= err_d;
        end
    end

endmodule

// File: tb/tb_lfsr_decrypt_engine.sv
// Testbench for lfsr_decrypt_engine: table-driven plan vectors, hand-written
// start-spam and mid-run reset sequences, and randomized messages checked
// against a message-level reference model.
module tb_lfsr_decrypt_engine;

    localparam int MSG_LEN  = 64;
    localparam int TD       = 7;
    localparam int ENC_BASE = 64;
    localparam int DEC_BASE = 0;
    localparam int NUM_TAPS = 6;
    localparam int LAT_MAX  = 2*TD + 2*MSG_LEN + 6;
    localparam logic [7:0] PRE_CHAR = 8'h5F;
    localparam logic [7:0] PAD_CHAR = 8'h20;
    localparam int K_RAND  = 0;
    localparam int K_HELLO = 1;
    localparam int K_ZERO  = 2;

    typedef struct {
        logic [5:0] tap;
        logic [5:0] seed;
        int         npre;
        int         kind;
        int         exp_tap;
        int         exp_err;
        int         exp_pre;
    } vec_t;

    logic       clk = 1'b0;
    logic       init;
    logic       start;
    logic [7:0] mem_raddr;
    logic [7:0] mem_rdata;
    logic       mem_we;
    logic [7:0] mem_waddr;
    logic [7:0] mem_wdata;
    logic       busy;
    logic       done;
    logic       err;
    logic [2:0] tap_idx;
    logic [6:0] pre_len;

    logic [7:0] mem [256];
    logic [7:0] img [256];
    logic       load_req;

    int n_cmp;
    int n_bad;

    int         exp_err, exp_tap, exp_pre, exp_writes;
    logic [7:0] exp_dec [MSG_LEN];

    int obs_we, obs_early_we, obs_done, done_cyc, obs_err, obs_tap, obs_pre;
    bit aborted;

    lfsr_decrypt_engine dut (
        .clk       (clk),
        .init      (init),
        .start     (start),
        .mem_raddr (mem_raddr),
        .mem_rdata (mem_rdata),
        .mem_we    (mem_we),
        .mem_waddr (mem_waddr),
        .mem_wdata (mem_wdata),
        .busy      (busy),
        .done      (done),
        .err       (err),
        .tap_idx   (tap_idx),
        .pre_len   (pre_len)
    );

    // Free-running clock.
    always #5 clk = ~clk;

    // Data memory with registered read; bulk load from the image on request.
    always @(posedge clk) begin
        if (load_req) begin
            for (int a = 0; a < 256; a++) mem[a] <= img[a];
        end else if (mem_we) begin
            mem[mem_waddr] <= mem_wdata;
        end
        mem_rdata <= mem[mem_raddr];
    end

    function automatic logic [5:0] lfsr_step(input logic [5:0] s, input logic [5:0] t);
        return {s[4:0], ^(s & t)};
    endfunction

    function automatic logic [5:0] tap_of(input int i);
        case (i)
            0: return 6'h21;
            1: return 6'h2D;
            2: return 6'h30;
            3: return 6'h33;
            4: return 6'h36;
            default: return 6'h39;
        endcase
    endfunction

    task automatic checkOutput(input string name, input int actual, input int expected);
        n_cmp++;
        if (actual != expected) begin
            n_bad++;
            $display("[TB] FAIL %s: got %0d (0x%0h), expected %0d (0x%0h)",
                     name, actual, actual, expected, expected);
        end
    endtask

    // Fill the memory image: random background, encrypted message at ENC_BASE.
    task automatic build_image(input vec_t v);
        logic [7:0]  plain [MSG_LEN];
        logic [5:0]  s;
        logic [39:0] hello;
        logic [7:0]  c;
        hello = "HELLO";
        for (int a = 0; a < 256; a++) img[a] = 8'($urandom_range(0, 255));
        if (v.kind == K_ZERO) begin
            for (int k = 0; k < MSG_LEN; k++) img[ENC_BASE + k] = 8'h00;
        end else begin
            for (int k = 0; k < MSG_LEN; k++) begin
                c = 8'($urandom_range(32, 126));
                if (c == PRE_CHAR) c = 8'h41;
                plain[k] = (k < v.npre) ? PRE_CHAR : c;
            end
            if (v.kind == K_HELLO) begin
                for (int i = 0; i < 5; i++) plain[v.npre + i] = hello[39 - 8*i -: 8];
            end
            s = v.seed;
            for (int k = 0; k < MSG_LEN; k++) begin
                img[ENC_BASE + k] = plain[k] ^ {2'b00, s};
                s = lfsr_step(s, v.tap);
            end
        end
    endtask

    // Reference: recover seed/tap from the image, decrypt, strip and pad.
    task automatic build_model();
        logic [5:0] obs [TD];
        logic [5:0] s;
        logic [7:0] plain [MSG_LEN];
        bit         ok;
        exp_err = 1; exp_tap = 0; exp_pre = 0; exp_writes = 0;
        for (int k = 0; k < TD; k++) obs[k] = img[ENC_BASE + k][5:0] ^ PRE_CHAR[5:0];
        for (int t = 0; t < NUM_TAPS; t++) begin
            s = obs[0];
            ok = 1;
            for (int k = 1; k < TD; k++) begin
                s = lfsr_step(s, tap_of(t));
                if (s != obs[k]) ok = 0;
            end
            if (ok && exp_err == 1) begin
                exp_err = 0;
                exp_tap = t;
            end
        end
        for (int k = 0; k < MSG_LEN; k++) exp_dec[k] = img[DEC_BASE + k];
        if (exp_err == 0) begin
            s = obs[0];
            for (int k = 0; k < MSG_LEN; k++) begin
                plain[k] = img[ENC_BASE + k] ^ {2'b00, s};
                s = lfsr_step(s, tap_of(exp_tap));
            end
            while (exp_pre < MSG_LEN && plain[exp_pre] == PRE_CHAR) exp_pre++;
            for (int k = 0; k < MSG_LEN; k++)
                exp_dec[k] = (k < MSG_LEN - exp_pre) ? plain[k + exp_pre] : PAD_CHAR;
            exp_writes = MSG_LEN + exp_pre +
                         ((exp_pre == 0 || exp_pre == MSG_LEN) ? 0 : MSG_LEN - exp_pre);
        end
    endtask

    task automatic load_memory();
        @(negedge clk) load_req = 1'b1;
        @(negedge clk) load_req = 1'b0;
    endtask

    // Issue start and observe the run; optionally spam start or reset mid-run.
    task automatic applyStimulus(input bit spam, input int abort_addr);
        int cyc;
        bit fin;
        cyc = 0; fin = 0;
        obs_we = 0; obs_early_we = 0; obs_done = 0; done_cyc = -1;
        obs_err = 0; obs_tap = 0; obs_pre = 0; aborted = 0;
        @(negedge clk) start = 1'b1;
        while (!fin) begin
            @(negedge clk);
            cyc++;
            if (cyc == 1) begin
                checkOutput("busy_after_start", busy, 1);
                checkOutput("err_cleared_on_start", err, 0);
                checkOutput("pre_len_cleared_on_start", pre_len, 0);
            end
            if (mem_we) begin
                obs_we++;
                if (cyc <= 2*TD) obs_early_we++;
            end
            if (abort_addr >= 0 && mem_we && int'(mem_waddr) == abort_addr) begin
                init = 1'b1;
                #1;
                checkOutput("abort_busy", busy, 0);
                checkOutput("abort_mem_we", mem_we, 0);
                checkOutput("abort_done", done, 0);
                aborted = 1;
                fin = 1;
            end else begin
                if (done) begin
                    obs_done++;
                    if (done_cyc < 0) begin
                        done_cyc = cyc;
                        obs_err  = err;
                        obs_tap  = tap_idx;
                        obs_pre  = pre_len;
                        checkOutput("busy_low_at_done", busy, 0);
                    end
                end
                start = (done_cyc >= 0 && cyc > done_cyc) ? 1'b0 : spam;
                if (done_cyc >= 0 && cyc >= done_cyc + 3) fin = 1;
                if (cyc >= LAT_MAX + 10) fin = 1;
            end
        end
        start = 1'b0;
        if (aborted) begin
            @(negedge clk) init = 1'b0;
        end else if (done_cyc < 0) begin
            checkOutput("done_timeout", 0, 1);
        end
    endtask

    // Compare a completed run against the reference model.
    task automatic check_run();
        int bad;
        bad = -1;
        checkOutput("done_pulse_count", obs_done, 1);
        checkOutput("latency_within_bound", (done_cyc > 0 && done_cyc <= LAT_MAX) ? 1 : 0, 1);
        checkOutput("err", obs_err, exp_err);
        checkOutput("tap_idx", obs_tap, exp_tap);
        checkOutput("pre_len", obs_pre, exp_pre);
        checkOutput("write_cycles", obs_we, exp_writes);
        checkOutput("writes_in_seed_match", obs_early_we, 0);
        checkOutput("err_held", err, exp_err);
        checkOutput("tap_idx_held", tap_idx, exp_tap);
        checkOutput("pre_len_held", pre_len, exp_pre);
        for (int k = 0; k < MSG_LEN; k++)
            if (mem[DEC_BASE + k] !== exp_dec[k] && bad < 0) bad = k;
        checkOutput("dec_mem_first_bad_offset", bad, -1);
    endtask

    initial begin
        vec_t       vecs [4];
        vec_t       rv;
        logic [39:0] hello;
        logic [7:0]  snap [MSG_LEN];
        int          bad;

        n_cmp = 0; n_bad = 0;
        init = 1'b1; start = 1'b0; load_req = 1'b0;
        hello = "HELLO";

        vecs[0] = '{tap: 6'h2D, seed: 6'h01, npre: 10, kind: K_HELLO, exp_tap: 1, exp_err: 0, exp_pre: 10};
        vecs[1] = '{tap: 6'h21, seed: 6'h3F, npre: TD, kind: K_RAND,  exp_tap: 0, exp_err: 0, exp_pre: TD};
        vecs[2] = '{tap: 6'h21, seed: 6'h01, npre: 0,  kind: K_ZERO,  exp_tap: 0, exp_err: 1, exp_pre: 0};
        vecs[3] = '{tap: 6'h21, seed: 6'h3F, npre: 64, kind: K_RAND,  exp_tap: 0, exp_err: 0, exp_pre: 64};

        repeat (2) @(negedge clk);
        checkOutput("reset_busy", busy, 0);
        checkOutput("reset_done", done, 0);
        checkOutput("reset_err", err, 0);
        checkOutput("reset_mem_we", mem_we, 0);
        checkOutput("reset_mem_raddr", mem_raddr, 0);
        checkOutput("reset_mem_waddr", mem_waddr, 0);
        checkOutput("reset_mem_wdata", mem_wdata, 0);
        checkOutput("reset_tap_idx", tap_idx, 0);
        checkOutput("reset_pre_len", pre_len, 0);
        @(negedge clk) init = 1'b0;

        $display("[TB] table-driven vectors");
        for (int v = 0; v < 4; v++) begin
            build_image(vecs[v]);
            load_memory();
            build_model();
            applyStimulus(1'b0, -1);
            check_run();
            checkOutput("tbl_err", obs_err, vecs[v].exp_err);
            checkOutput("tbl_tap_idx", obs_tap, vecs[v].exp_tap);
            checkOutput("tbl_pre_len", obs_pre, vecs[v].exp_pre);
            if (vecs[v].kind == K_HELLO) begin
                for (int i = 0; i < 5; i++)
                    checkOutput("hello_char", mem[DEC_BASE + i], hello[39 - 8*i -: 8]);
                for (int i = 54; i < 64; i++)
                    checkOutput("hello_pad", mem[DEC_BASE + i], PAD_CHAR);
            end
        end

        $display("[TB] error run then start held high through a good run");
        build_image(vecs[2]);
        load_memory();
        build_model();
        applyStimulus(1'b0, -1);
        check_run();
        build_image(vecs[0]);
        load_memory();
        build_model();
        applyStimulus(1'b1, -1);
        check_run();

        $display("[TB] reset during decode, then a clean rerun");
        build_image(vecs[0]);
        load_memory();
        build_model();
        for (int k = 0; k < MSG_LEN; k++) snap[k] = img[DEC_BASE + k];
        applyStimulus(1'b0, DEC_BASE + 20);
        checkOutput("abort_reached", aborted, 1);
        bad = -1;
        for (int k = 21; k < MSG_LEN; k++)
            if (mem[DEC_BASE + k] !== snap[k] && bad < 0) bad = k;
        checkOutput("abort_tail_untouched_first_bad", bad, -1);
        applyStimulus(1'b0, -1);
        check_run();

        $display("[TB] randomized messages");
        for (int r = 0; r < 6; r++) begin
            rv.tap     = tap_of($urandom_range(0, NUM_TAPS - 1));
            rv.seed    = 6'($urandom_range(0, 63));
            rv.npre    = $urandom_range(0, MSG_LEN);
            rv.kind    = K_RAND;
            rv.exp_tap = 0; rv.exp_err = 0; rv.exp_pre = 0;
            build_image(rv);
            load_memory();
            build_model();
            applyStimulus(1'b0, -1);
            check_run();
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
